// File: rtl/tree_8in_rr_grant.sv
// tree_8in_rr_grant: responder behind the 8-input OR-reduction request trees.
// The block picks one requester with round-robin fairness. It then presents a
// registered one-hot grant to a single consumer over a valid/ready handshake.
module tree_8in_rr_grant #(
  parameter int unsigned PTR_RESET = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       grant_ready,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       req_any
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  localparam logic [2:0] PTR_INIT = 3'(PTR_RESET);

  // First set bit of v, searching p, p+1, ..., p+7 (mod 8).
  // Walking downward lets the lowest rotation offset overwrite the rest.
  function automatic logic [2:0] f_sel(input logic [7:0] v, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] res;
    res = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (v[idx]) begin
        res = idx;
      end
    end
    return res;
  endfunction

  // Binary index to one-hot vector.
  function automatic logic [7:0] f_onehot(input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'd0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  logic [0:0] r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_grant;
  logic [2:0] r_grant_idx;
  logic       r_grant_valid;
  logic       r_req_any;

  logic [0:0] w_state_nxt;
  logic [2:0] w_ptr_nxt;
  logic [7:0] w_grant_nxt;
  logic [2:0] w_grant_idx_nxt;
  logic       w_grant_valid_nxt;
  logic       w_req_any;
  logic [2:0] w_base;
  logic [2:0] w_sel_idx;

  // Next-state logic. An accept re-arbitrates from the slot after the served one.
  // That same-cycle re-arbitration makes back-to-back grants bubble-free.
  always_comb begin
    w_req_any         = |req;
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_grant_nxt       = r_grant;
    w_grant_idx_nxt   = r_grant_idx;
    w_grant_valid_nxt = r_grant_valid;

    case (r_state)
      S_IDLE:  w_base = r_ptr;
      S_GRANT: w_base = r_grant_idx + 3'd1;
      default: w_base = r_ptr;
    endcase
    w_sel_idx = f_sel(req, w_base);

    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_state_nxt       = S_GRANT;
          w_grant_nxt       = f_onehot(w_sel_idx);
          w_grant_idx_nxt   = w_sel_idx;
          w_grant_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (grant_ready) begin
          w_ptr_nxt = r_grant_idx + 3'd1;
          if (w_req_any) begin
            w_state_nxt       = S_GRANT;
            w_grant_nxt       = f_onehot(w_sel_idx);
            w_grant_idx_nxt   = w_sel_idx;
            w_grant_valid_nxt = 1'b1;
          end else begin
            // Drain: grant_idx keeps the last served index.
            w_state_nxt       = S_IDLE;
            w_grant_nxt       = 8'd0;
            w_grant_valid_nxt = 1'b0;
          end
        end else begin
          // Stalled. The grant is held even if the granted request drops.
          w_state_nxt = S_GRANT;
        end
      end
      default: begin
        w_state_nxt       = S_IDLE;
        w_grant_nxt       = 8'd0;
        w_grant_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset drops any outstanding grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= PTR_INIT;
      r_grant       <= 8'd0;
      r_grant_idx   <= 3'd0;
      r_grant_valid <= 1'b0;
      r_req_any     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_req_any     <= w_req_any;
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_grant_valid;
  assign req_any     = r_req_any;

endmodule

// File: doc/tree_8in_rr_grant.md
Name: tree_8in_rr_grant

Overview:
- Responder end of the 8-input OR-reduction request trees.
- The OR tree reports only that some input requested. This block resolves which input is served, and returns a registered one-hot grant to the 8 sources using round-robin fairness.
- A single consumer accepts grants through a valid/ready handshake.
- Sits directly behind an 8-source request fabric, alongside the OR-tree aggregators.

Parameters:
PTR_RESET, 0, reset value (0..7) of the round-robin search pointer, i.e. the highest-priority index after reset.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  8  request lines, bit i = source i; level-sensitive
grant_ready  input  1  consumer accepts current grant when high with grant_valid
grant  output  8  registered one-hot grant; all-zero when grant_valid=0
grant_idx  output  3  binary index of the set grant bit; holds last value when idle
grant_valid  output  1  grant/grant_idx are valid
req_any  output  1  registered OR of req, 1-cycle latency

Behaviour:
Reset:
- rst_n low forces the following immediately, regardless of clk: grant=0, grant_idx=0, grant_valid=0, req_any=0, ptr=PTR_RESET, state=IDLE.
- Reset asserted mid-grant drops the grant without a handshake.

Selection function sel(v, p):
- Returns the first index i with v[i]=1, searching p, p+1, ..., p+7, all mod 8.
- Only defined when v is nonzero.

Pointer:
- ptr is 3 bits, wraps 7->0.
- Updated only on acceptance: ptr <= grant_idx+1 mod 8.

State machine (IDLE, GRANT):
- IDLE, req=0: stay in IDLE; outputs unchanged.
- IDLE, req!=0: next cycle grant=onehot(sel(req,ptr)), grant_idx=sel(req,ptr), grant_valid=1, state=GRANT.
  - Latency is 1 cycle from req to grant_valid.
- GRANT, grant_ready=0: grant, grant_idx and grant_valid are held stable. They must not change even if req changes, including when the granted bit drops (no revocation).
- GRANT, grant_ready=1 (accept), with p' = grant_idx+1 mod 8:
  - If req!=0 in the accept cycle: next cycle carries a new grant sel(req,p'); stay in GRANT; grant_valid stays 1.
    - This allows back-to-back grants at one per cycle.
    - The just-served source is eligible again, but at lowest priority.
  - If req=0: next cycle grant=0, grant_valid=0, state=IDLE. grant_idx retains its last value.
- The accept cycle samples req combinationally from the same cycle. There is no extra bubble.

req_any:
- req_any <= |req every cycle, independent of the state machine.

Invariants:
- grant is one-hot or zero.
- grant==0 iff grant_valid=0.
- When grant_valid=1, grant[grant_idx]=1.
- No source is granted twice while another source continuously requests: maximum wait is 7 accepted grants.

Test Plan:
- Reset/idle: hold rst_n=0, req=8'hFF -> all outputs 0. Release rst_n with req=0 for 5 cycles -> grant_valid stays 0, req_any=0.
- Single request: PTR_RESET=0, req=8'h20 at cycle N -> cycle N+1 grant=8'h20, grant_idx=5, grant_valid=1, req_any=1. With grant_ready held 0 for 4 cycles and req dropped to 0 -> outputs unchanged.
- Round-robin fairness: req=8'hFF constant, grant_ready=1 constant -> grant_idx sequence 0,1,2,...,7,0 on consecutive cycles, grant_valid never drops.
- Wrap and skip: PTR_RESET=0, req=8'h81, grant_ready=1 -> grant_idx 0,7,0,7. Then req=8'h02 with ptr=1 -> grant_idx=1.
- Back-to-back vs drain: in GRANT with idx=3, accept with req=8'h08 -> next grant idx=3 again (only requester). Accept with req=0 -> next cycle grant_valid=0, grant=0, grant_idx=3.
- Async reset mid-grant: while grant_valid=1, pulse rst_n low between clock edges -> grant_valid falls before the next edge. After release, req=8'hFF -> first grant_idx=PTR_RESET.
